uart_rx_framer: RTL

Serial-to-parallel UART receive stage.
- Synchronizes the asynchronous `serial_in` line to `clock`.
- Detects start bits and samples each bit at its center.
- Delivers one `DATA_BITS`-wide word per frame with a single-cycle valid strobe.
- Sits directly downstream of the UART line pins and upstream of the receive buffer and host logic.

---
 rtl/uart_rx_framer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//
// Serial-to-parallel UART receive stage. Synchronizes the raw RX line,
// detects the start bit, samples every bit at its centre and delivers one
// DATA_BITS-wide word per good frame with a single-cycle valid strobe.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the payload and the stop bit. Without it, parity_error is tied 0
// and the port list is unchanged.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//   DATA_BITS     payload bits per frame (5..9), LSB first
//
// Ports:
//   clock          system clock, all state updates on posedge
//   reset          asynchronous active-high reset
//   serial_in      raw asynchronous RX line, idles high
//   data_out       last good received word, held until the next good frame
//   data_valid     one-cycle pulse when data_out is updated
//   framing_error  one-cycle pulse when the stop bit samples 0
//   parity_error   one-cycle pulse on parity mismatch (0 without parity)
//   busy           high whenever the FSM is not idle
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | line idle, waiting for rx_s == 0
// START   | counting to the start-bit centre, rejecting glitches
// DATA    | sampling DATA_BITS payload bits, one per bit period
// PARITY  | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP    | sampling the stop bit and issuing the result pulse
// BREAK   | stop bit was 0; waiting for the line to return high

module uart_rx_framer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 parity_error,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t               state, state_nxt;
   logic                 sync1, rx_s;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic [DATA_BITS-1:0] data_nxt;
   logic                 valid_nxt, ferr_nxt, perr_nxt;
   logic                 bit_end;

`ifdef UART_RX_PARITY_EN
   logic                 par_bad, par_bad_nxt;
`endif

   // Synchronizer flops reset to the idle level so reset never fakes a start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= serial_in;
         rx_s  <= sync1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         idx           <= '0;
         shift         <= '0;
         data_out      <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         parity_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad       <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         idx           <= idx_nxt;
         shift         <= shift_nxt;
         data_out      <= data_nxt;
         data_valid    <= valid_nxt;
         framing_error <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
         parity_error  <= perr_nxt;
         par_bad       <= par_bad_nxt;
`else
         parity_error  <= 1'b0;
`endif
      end
   end

   // The start bit is sampled half a bit after detection; every later bit
   // one full bit period after the previous sample.
   assign bit_end = (state == ST_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_nxt = shift;
      data_nxt  = data_out;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt = par_bad;
`endif

      if (state != ST_IDLE && state != ST_BREAK) begin
         cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
      end

      case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               state_nxt = ST_START;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
               if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               // Even parity: payload plus parity bit must hold an even count of ones.
               par_bad_nxt = rx_s ^ (^shift);
               state_nxt   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (rx_s) begin
                  state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) begin
                     perr_nxt = 1'b1;
                  end else begin
                     data_nxt  = shift;
                     valid_nxt = 1'b1;
                  end
`else
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
`endif
               end else begin
                  // Framing error takes precedence over any parity result.
                  ferr_nxt  = 1'b1;
                  state_nxt = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

endmodule
